lsu_mem_initiator: RTL

- Initiator side of the physical-memory request interface: turns core load/store requests into single-word memory accesses for the DPI-backed memory controller.
- Drives valid/wen/raddr/waddr/wdata/wmask and samples rdata.
- Sits between the execute stage and the memory controller.
- Handles byte-lane alignment, write masks, load extension, misalignment detection and a valid/ready handshake toward the core.

---
 rtl/lsu_mem_initiator.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns one core request into a single word-aligned memory access.
// Optional build macro LSU_PERF_CNT_EN adds load/store/error response counters.
module lsu_mem_initiator #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
`ifdef LSU_PERF_CNT_EN
  output logic [31:0] perf_load_cnt,
  output logic [31:0] perf_store_cnt,
  output logic [31:0] perf_err_cnt,
`endif
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  logic [1:0]  state_reg;
  logic        wen_reg;
  logic [1:0]  off_reg;
  logic [1:0]  size_reg;
  logic        signed_reg;
  logic [3:0]  cnt_reg;
  logic        resp_err_reg;
  logic [31:0] resp_rdata_reg;
  logic        mem_valid_reg;
  logic        mem_wen_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [7:0]  mem_wmask_reg;

  logic        misaligned;
  logic [31:0] store_wdata;
  logic [7:0]  store_mask;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign misaligned = (req_size == 2'd3) ||
                      (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && req_addr[1:0] != 2'd0);

  assign store_wdata = req_wdata << {req_addr[1:0], 3'b000};

  // One enable per byte lane; the upper half of the mask is never used.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign store_mask[gi] = (req_size == 2'd2) ||
                              (req_size == 2'd1 && req_addr[1] == 1'(gi / 2)) ||
                              (req_size == 2'd0 && req_addr[1:0] == 2'(gi));
    end
    for (genvar gi = 4; gi < 8; gi++) begin : g_lane_hi
      assign store_mask[gi] = 1'b0;
    end
  endgenerate

  always_comb begin
    shifted   = mem_rdata >> {off_reg, 3'b000};
    load_data = shifted;
    case (size_reg)
      2'd0:    load_data = {{24{signed_reg & shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{16{signed_reg & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wen_reg        <= 1'b0;
      off_reg        <= 2'd0;
      size_reg       <= 2'd0;
      signed_reg     <= 1'b0;
      cnt_reg        <= 4'd0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'd0;
      mem_valid_reg  <= 1'b0;
      mem_wen_reg    <= 1'b0;
      mem_addr_reg   <= 32'd0;
      mem_wdata_reg  <= 32'd0;
      mem_wmask_reg  <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            wen_reg    <= req_wen;
            off_reg    <= req_addr[1:0];
            size_reg   <= req_size;
            signed_reg <= req_signed;
            if (misaligned) begin
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= 32'd0;
              state_reg      <= RESP;
            end else begin
              // mem_* are loaded here so they are registered for the whole access.
              state_reg     <= ACCESS;
              cnt_reg       <= LAT_INIT;
              mem_valid_reg <= 1'b1;
              mem_wen_reg   <= req_wen;
              mem_addr_reg  <= {req_addr[31:2], 2'b00};
              mem_wdata_reg <= req_wen ? store_wdata : 32'd0;
              mem_wmask_reg <= req_wen ? store_mask : 8'd0;
            end
          end
        end
        ACCESS: begin
          if (wen_reg || cnt_reg == 4'd0) begin
            mem_valid_reg  <= 1'b0;
            mem_wen_reg    <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_wdata_reg  <= 32'd0;
            mem_wmask_reg  <= 8'd0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= wen_reg ? 32'd0 : load_data;
            state_reg      <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_err_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_load_reg;
  logic [31:0] perf_store_reg;
  logic [31:0] perf_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_load_reg  <= 32'd0;
      perf_store_reg <= 32'd0;
      perf_err_reg   <= 32'd0;
    end else if (state_reg == RESP && resp_ready) begin
      if (resp_err_reg)  perf_err_reg   <= perf_err_reg + 32'd1;
      else if (wen_reg)  perf_store_reg <= perf_store_reg + 32'd1;
      else               perf_load_reg  <= perf_load_reg + 32'd1;
    end
  end

  assign perf_load_cnt  = perf_load_reg;
  assign perf_store_cnt = perf_store_reg;
  assign perf_err_cnt   = perf_err_reg;
`endif

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;
  assign mem_valid  = mem_valid_reg;
  assign mem_wen    = mem_wen_reg;
  assign mem_raddr  = mem_addr_reg;
  assign mem_waddr  = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign mem_wmask  = mem_wmask_reg;

endmodule
